// File: rtl/arbitro_barramento.sv
// Round-robin arbiter + read sequencer: grants one master, strobes the bus, waits for ack or timeout.
// Latency: grant 1 cycle after req sampled, done 2 cycles after grant on immediate ack; no backpressure, req is held until done.
module arbitro_barramento #(
    parameter int N_REQ   = 4,
    parameter int ADDR_W  = 4,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 15
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [N_REQ-1:0]          req,
    input  logic [N_REQ*ADDR_W-1:0]   req_adr,
    output logic [N_REQ-1:0]          gnt,
    output logic [N_REQ-1:0]          done,
    output logic                      err,
    output logic [DATA_W-1:0]         rdata,
    output logic                      bus_rd,
    output logic [ADDR_W-1:0]         bus_adr,
    input  logic [DATA_W-1:0]         bus_q,
    input  logic                      bus_ack
);
    localparam int IDX_W = $clog2(N_REQ);
    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [N_REQ-1:0] ONE = 1;

    typedef enum logic [1:0] {IDLE, ADDR, WAIT, DONE} state_t;

    state_t            state;
    logic [IDX_W-1:0]  ptr;
    logic [IDX_W-1:0]  idx;
    logic [CNT_W-1:0]  cnt;

    logic [ADDR_W-1:0] adr_arr [N_REQ];
    logic              pick_vld;
    logic [IDX_W-1:0]  pick_idx;
    logic [IDX_W:0]    sum;
    logic [IDX_W-1:0]  cand;

    for (genvar i = 0; i < N_REQ; i++) begin : g_adr
        assign adr_arr[i] = req_adr[i*ADDR_W +: ADDR_W];
    end

    // Scan from the highest offset down so the candidate nearest ptr is the one kept.
    always_comb begin
        pick_vld = 1'b0;
        pick_idx = '0;
        sum      = '0;
        cand     = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            sum = {1'b0, ptr} + (IDX_W+1)'(k);
            if (sum >= (IDX_W+1)'(N_REQ)) begin
                sum = sum - (IDX_W+1)'(N_REQ);
            end
            cand = sum[IDX_W-1:0];
            if (req[cand]) begin
                pick_vld = 1'b1;
                pick_idx = cand;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            gnt     <= '0;
            done    <= '0;
            err     <= 1'b0;
            rdata   <= '0;
            bus_rd  <= 1'b0;
            bus_adr <= '0;
            ptr     <= '0;
            idx     <= '0;
            cnt     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_vld) begin
                        idx     <= pick_idx;
                        gnt     <= ONE << pick_idx;
                        bus_rd  <= 1'b1;
                        bus_adr <= adr_arr[pick_idx];
                        state   <= ADDR;
                    end
                end
                ADDR: begin
                    cnt   <= '0;
                    state <= WAIT;
                end
                WAIT: begin
                    // An ack arriving on the final allowed cycle still counts as success.
                    if (bus_ack) begin
                        rdata <= bus_q;
                        done  <= ONE << idx;
                        err   <= 1'b0;
                        state <= DONE;
                    end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
                        done  <= ONE << idx;
                        err   <= 1'b1;
                        state <= DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    done   <= '0;
                    err    <= 1'b0;
                    gnt    <= '0;
                    bus_rd <= 1'b0;
                    ptr    <= (idx == IDX_W'(N_REQ - 1)) ? '0 : idx + 1'b1;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_arbitro_barramento.sv
// Randomised bench for arbitro_barramento: a transaction-level model predicts each grant and its completion.
module tb_arbitro_barramento;
    localparam int N_REQ   = 4;
    localparam int ADDR_W  = 4;
    localparam int DATA_W  = 32;
    localparam int TIMEOUT = 15;
    localparam int IDX_W   = $clog2(N_REQ);

    typedef logic [N_REQ-1:0][ADDR_W-1:0] adr_vec_t;

    typedef struct {
        int                idx;
        logic [ADDR_W-1:0] adr;
        logic              err;
        logic [DATA_W-1:0] rdata;
        int                done_e;
    } exp_t;

    logic                    clk = 1'b0;
    logic                    rst;
    logic [N_REQ-1:0]        req;
    adr_vec_t                adr_pk;
    logic [N_REQ*ADDR_W-1:0] req_adr;
    logic [N_REQ-1:0]        gnt;
    logic [N_REQ-1:0]        done;
    logic                    err;
    logic [DATA_W-1:0]       rdata;
    logic                    bus_rd;
    logic [ADDR_W-1:0]       bus_adr;
    logic [DATA_W-1:0]       bus_q;
    logic                    bus_ack;

    assign req_adr = adr_pk;

    always #5 clk = ~clk;

    arbitro_barramento #(
        .N_REQ(N_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .rst(rst), .req(req), .req_adr(req_adr),
        .gnt(gnt), .done(done), .err(err), .rdata(rdata),
        .bus_rd(bus_rd), .bus_adr(bus_adr), .bus_q(bus_q), .bus_ack(bus_ack)
    );

    exp_t              exp_q[$];
    int                n_vec = 0;
    int                n_err = 0;
    int                edge_n = 0;
    int                ptr_m = 0;
    int                free_e = 0;
    int                cur_w = -1;
    int                cur_ack_e = -1;
    int                cur_done_e = -1;
    int                force_d = -1;
    int                last_idx = 0;
    logic [DATA_W-1:0] cur_q = '0;
    logic [DATA_W-1:0] last_rd = '0;
    logic [DATA_W-1:0] force_q = '0;
    logic              force_q_vld = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        n_vec++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (edge %0d)", name, act, expv, edge_n);
        end
    endtask

    // Apply inputs for the next rising edge, update the model, then step past that edge.
    task automatic drive_edge(input logic rst_v, input logic [N_REQ-1:0] rq, input adr_vec_t adr_v);
        int   nx;
        int   idx;
        int   j;
        int   d;
        exp_t e;
        nx = edge_n + 1;
        rst = rst_v;
        req = rq;
        adr_pk = adr_v;
        if (rst_v) begin
            if (cur_done_e >= nx && exp_q.size() > 0) begin
                exp_q.delete(exp_q.size() - 1);
            end
            cur_done_e = -1;
            cur_w = -1;
            cur_ack_e = -1;
            ptr_m = 0;
            last_rd = '0;
            free_e = nx + 1;
        end else if (nx >= free_e && rq != '0) begin
            idx = -1;
            for (int k = 0; k < N_REQ; k++) begin
                j = (ptr_m + k) % N_REQ;
                if (idx < 0 && rq[IDX_W'(j)]) idx = j;
            end
            if (force_d >= 0) begin
                d = force_d;
            end else begin
                case ($urandom_range(0, 7))
                    0, 1, 2: d = 0;
                    3:       d = TIMEOUT - 1;
                    4:       d = TIMEOUT;
                    default: d = int'($urandom_range(0, TIMEOUT - 1));
                endcase
            end
            e.idx = idx;
            e.adr = adr_v[IDX_W'(idx)];
            cur_w = nx + 2;
            if (d < TIMEOUT) begin
                cur_ack_e = nx + 2 + d;
                cur_q = force_q_vld ? force_q : $urandom;
                e.err = 1'b0;
                e.rdata = cur_q;
                last_rd = cur_q;
                e.done_e = cur_ack_e;
            end else begin
                cur_ack_e = -1;
                e.err = 1'b1;
                e.rdata = last_rd;
                e.done_e = nx + 2 + TIMEOUT - 1;
            end
            cur_done_e = e.done_e;
            free_e = e.done_e + 2;
            ptr_m = (idx + 1) % N_REQ;
            last_idx = idx;
            exp_q.push_back(e);
        end
        if (!rst_v && nx >= cur_w && nx <= cur_done_e) begin
            bus_ack = (nx == cur_ack_e);
            bus_q = bus_ack ? cur_q : $urandom;
        end else begin
            bus_ack = ($urandom_range(0, 3) == 0);
            bus_q = $urandom;
        end
        @(posedge clk);
        #1;
        edge_n++;
    endtask

    task automatic run_txn(input logic [N_REQ-1:0] rq, input adr_vec_t adr, input int d,
                           input logic [DATA_W-1:0] q, input logic drop);
        logic [N_REQ-1:0] oh;
        int guard;
        force_d = d;
        force_q = q;
        force_q_vld = 1'b1;
        guard = 0;
        while (edge_n + 1 < free_e && guard < 100) begin
            drive_edge(1'b0, '0, adr);
            guard++;
        end
        drive_edge(1'b0, rq, adr);
        oh = '0;
        oh[IDX_W'(last_idx)] = 1'b1;
        chk("grant_gnt", 64'(gnt), 64'(oh));
        chk("grant_bus_rd", 64'(bus_rd), 64'd1);
        chk("grant_bus_adr", 64'(bus_adr), 64'(adr[IDX_W'(last_idx)]));
        guard = 0;
        while (edge_n < cur_done_e && guard < 100) begin
            drive_edge(1'b0, drop ? '0 : rq, adr);
            guard++;
        end
        drive_edge(1'b0, '0, adr);
        force_d = -1;
        force_q_vld = 1'b0;
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_gnt"}, 64'(gnt), 64'd0);
        chk({tag, "_done"}, 64'(done), 64'd0);
        chk({tag, "_err"}, 64'(err), 64'd0);
        chk({tag, "_rdata"}, 64'(rdata), 64'd0);
        chk({tag, "_bus_rd"}, 64'(bus_rd), 64'd0);
        chk({tag, "_bus_adr"}, 64'(bus_adr), 64'd0);
    endtask

    // Monitor: every done pulse must match the oldest predicted transaction.
    exp_t             m_e;
    logic [N_REQ-1:0] m_oh;
    initial begin
        forever begin
            @(negedge clk);
            if (done !== '0) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_done", 64'(done), 64'd0);
                end else begin
                    m_e = exp_q.pop_front();
                    m_oh = '0;
                    m_oh[IDX_W'(m_e.idx)] = 1'b1;
                    chk("done_vec", 64'(done), 64'(m_oh));
                    chk("done_cycle", 64'(edge_n), 64'(m_e.done_e));
                    chk("err", 64'(err), 64'(m_e.err));
                    chk("rdata", 64'(rdata), 64'(m_e.rdata));
                    chk("done_gnt", 64'(gnt), 64'(m_oh));
                    chk("done_bus_adr", 64'(bus_adr), 64'(m_e.adr));
                    chk("done_bus_rd", 64'(bus_rd), 64'd1);
                end
            end
        end
    end

    initial begin
        adr_vec_t         v;
        logic [N_REQ-1:0] rq;
        int               guard;
        rst = 1'b1;
        req = '0;
        adr_pk = '0;
        bus_q = '0;
        bus_ack = 1'b0;
        for (int i = 0; i < 3; i++) drive_edge(1'b1, '0, adr_vec_t'($urandom));
        chk_reset_state("reset");

        // Single master, immediate ack.
        v = adr_vec_t'($urandom);
        v[0] = 4'h3;
        run_txn(4'b0001, v, 0, 32'hDEADBEEF, 1'b0);
        // Timeout: rdata must keep DEADBEEF.
        run_txn(4'b0100, adr_vec_t'($urandom), TIMEOUT, 32'h0, 1'b0);
        // Ack on the last permitted WAIT cycle.
        run_txn(4'b1000, adr_vec_t'($urandom), TIMEOUT - 1, 32'h1234, 1'b0);
        // Requester drops req during WAIT; transaction still completes.
        run_txn(4'b0010, adr_vec_t'($urandom), 3, $urandom, 1'b1);

        // Fairness with all masters requesting.
        for (int c = 0; c < 60; c++) drive_edge(1'b0, 4'b1111, adr_vec_t'($urandom));

        // Random request churn.
        rq = '0;
        for (int c = 0; c < 800; c++) begin
            rq = rq ^ (N_REQ'($urandom) & N_REQ'($urandom) & N_REQ'($urandom));
            drive_edge(1'b0, rq, adr_vec_t'($urandom));
        end

        // Reset while waiting for an ack.
        guard = 0;
        while (edge_n + 1 < free_e && guard < 100) begin
            drive_edge(1'b0, '0, adr_vec_t'($urandom));
            guard++;
        end
        force_d = TIMEOUT;
        v = adr_vec_t'($urandom);
        drive_edge(1'b0, 4'b0100, v);
        drive_edge(1'b0, '0, v);
        drive_edge(1'b0, '0, v);
        drive_edge(1'b1, '0, v);
        force_d = -1;
        chk_reset_state("midrst");
        run_txn(4'b0010, adr_vec_t'($urandom), 0, $urandom, 1'b0);

        // Drain and confirm every predicted completion was seen.
        guard = 0;
        while (edge_n <= free_e && guard < 100) begin
            drive_edge(1'b0, '0, adr_vec_t'($urandom));
            guard++;
        end
        chk("pending_left", 64'(exp_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
